seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, registered ALU for the RISC datapath; successor to the single-cycle 4-op ALU.
- Adds a valid/ready handshake on input and output, registered Z/N/V/C flags, shift and OR/XOR ops, and an iterative shift-add multiply.
- Sits between the register-file read stage and writeback; the controller FSM drives in_valid and consumes out_valid.

Parameters:
- WIDTH, 16, operand and result width (>=4, power of 2).
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL is an illegal op.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept this cycle.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 MVN(~b), 100 OR, 101 XOR, 110 LSL, 111 MUL.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- z, n, v, c  out  1 each  registered flags, paired with result.
- busy  out  1  multiply in progress.

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately, including mid-multiply (the partial product is discarded).
  - All outputs 0; state IDLE.
  - in_ready goes to 1 on the first clk edge after rst_n deasserts.
- States:
  - IDLE: accept when in_valid & in_ready.
  - MUL: iterate; in_ready=0, busy=1.
  - No other states.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- Single-cycle ops (ADD..LSL):
  - Accept at edge k; result, flags and out_valid=1 are registered at edge k.
  - Throughput is 1/cycle while out_ready=1.
- Accept with out_valid=1 & out_ready=1 in the same cycle: the old result is consumed and the new one replaces it at that edge.
- Backpressure: while out_valid & !out_ready, result and flags hold stable and in_ready=0.
- Output pop with no accept: out_valid cleared at the edge; result and flags hold their last values.
- MUL (MUL_EN=1):
  - On accept, go to MUL; clear the 2*WIDTH accumulator; latch a and b.
  - One shift-add step per cycle for WIDTH cycles.
  - At the WIDTH-th MUL edge, register result = low WIDTH bits, set out_valid=1, return to IDLE.
  - Latency: WIDTH edges after accept; in_ready=0 throughout.
- MUL with MUL_EN=0: completes as a single-cycle op with result=0, z=1, v=1, n=0, c=0.
- Arithmetic:
  - All ops are modulo 2^WIDTH.
  - ADD: c = carry out.
  - SUB = a + ~b + 1; c = carry out (1 = no borrow).
- Flags:
  - z = (result==0).
  - n = result[WIDTH-1].
  - v, ADD: sign(a)==sign(b) & sign(result)!=sign(a).
  - v, SUB: sign(a)!=sign(b) & sign(result)!=sign(a).
  - v, AND/MVN/OR/XOR: v=0, c=0.
  - LSL: shift amount = b[log2(WIDTH)-1:0]. c = last bit shifted out (0 when amount 0); v=0.
  - MUL: unsigned. v = c = (high WIDTH bits of the product != 0).
- Illegal input: op or operands X while in_valid=1 is an assertion failure in simulation.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e enum (3-bit, codes above).
  - alu_state_e {IDLE, MUL}.
  - alu_flags_t struct {z,n,v,c}.
- One sub-module, seq_alu_mul:
  - Iterative unsigned shift-add multiplier.
  - Ports: start, a, b, done, product[2*WIDTH].
  - Instantiated only under MUL_EN=1 via a generate block.

Test Plan (WIDTH=16):
- Reset: rst_n=0 mid-run -> all outputs 0 immediately; in_ready=1 one edge after release.
- Add/sub flags:
  - ADD 0x7FFF+0x0001, out_ready=1 -> next edge result=0x8000, n=1, v=1, c=0, z=0.
  - SUB 0x0005-0x0005 -> result=0, z=1, c=1, v=0.
- Back-to-back with stall:
  - Three ops on consecutive cycles with out_ready=1 -> three results on consecutive cycles.
  - Hold out_ready=0 for 4 cycles -> result stable and in_ready=0 until released.
- LSL:
  - 0x8001 by b=1 -> result=0x0002, c=1.
  - By b=0x0010 (amount 0) -> result=0x8001, c=0.
- MUL:
  - 0x0100*0x0100 -> busy=1 for 16 cycles, then result=0x0000, z=1, v=1, c=1.
  - 0x0003*0x0007 -> result=0x0015, v=0.
  - in_ready=0 throughout both multiplies.
- MUL abort: rst_n=0 at MUL cycle 8 -> outputs 0 and no out_valid; a fresh ADD 1+1 after release returns 0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// registered flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_MVN = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LSL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic c;
    } alu_flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// WIDTH steps after a start pulse. done and product are valid in the last step cycle.
module seq_alu_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    logic                 run_q, run_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_sum;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (run_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == LAST_STEP) begin
                run_d = 1'b0;
            end
        end
    end

    // The final step's sum is handed out directly so the top can register it on the same edge.
    assign done    = run_q && (cnt_q == LAST_STEP);
    assign product = acc_sum;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides, registered Z/N/V/C flags and an
// optional iterative multiply that stalls the input for WIDTH cycles.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             c,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    alu_flags_t        flags_q, flags_d;
    logic              rdy_en_q, rdy_en_d;

    alu_op_e           op_e;
    logic              accept;
    logic              mul_start;
    logic              mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]  alu_res;
    alu_flags_t        alu_flags;
    logic [WIDTH:0]    add_w, sub_w;
    logic [2*WIDTH-1:0] shl_w;
    logic [SHW-1:0]    shamt;

    assign op_e     = alu_op_e'(op);
    // rdy_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready = rdy_en_q && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        add_w     = {1'b0, a} + {1'b0, b};
        sub_w     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        shamt     = b[SHW-1:0];
        shl_w     = {{WIDTH{1'b0}}, a} << shamt;

        case (op_e)
            OP_ADD: begin
                alu_res     = add_w[WIDTH-1:0];
                alu_flags.c = add_w[WIDTH];
                alu_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res     = sub_w[WIDTH-1:0];
                alu_flags.c = sub_w[WIDTH];
                alu_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_MVN: alu_res = ~b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_LSL: begin
                // Bit WIDTH of the widened shift is the last bit pushed out; zero for amount 0.
                alu_res     = shl_w[WIDTH-1:0];
                alu_flags.c = shl_w[WIDTH];
            end
            // Only reached with the multiplier absent: MUL is illegal and flagged via v.
            OP_MUL: alu_flags.v = 1'b1;
            default: alu_res = '0;
        endcase

        alu_flags.z = (alu_res == '0);
        alu_flags.n = alu_res[WIDTH-1];
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        rdy_en_d    = 1'b1;
        mul_start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((MUL_EN != 0) && (op_e == OP_MUL)) begin
                        mul_start   = 1'b1;
                        state_d     = MUL;
                        out_valid_d = 1'b0;
                    end else begin
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        out_valid_d = 1'b1;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            MUL: begin
                if (mul_done) begin
                    result_d    = mul_product[WIDTH-1:0];
                    flags_d.z   = (mul_product[WIDTH-1:0] == '0);
                    flags_d.n   = mul_product[WIDTH-1];
                    flags_d.v   = |mul_product[2*WIDTH-1:WIDTH];
                    flags_d.c   = |mul_product[2*WIDTH-1:WIDTH];
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign z         = flags_q.z;
    assign n         = flags_q.n;
    assign v         = flags_q.v;
    assign c         = flags_q.c;
    assign busy      = (state_q == MUL);

`ifndef SYNTHESIS
    a_no_x_inputs : assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> !$isunknown({op, a, b}));
`endif

endmodule
